// File: rtl/acc_poll_scheduler_pkg.sv
// Shared types and default register constants for the accelerometer poll scheduler.
package acc_pkg;

    typedef enum logic [2:0] {
        INIT_REQ,
        INIT_WAIT,
        IDLE,
        RD_REQ,
        RD_WAIT,
        PUBLISH,
        ERROR
    } acc_state_e;

    localparam logic [7:0] ACC_INIT_REG  = 8'h2D;
    localparam logic [7:0] ACC_INIT_DATA = 8'h08;
    localparam logic [7:0] ACC_DATA_REG0 = 8'h32;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } acc_sample_t;

endpackage

// File: rtl/acc_poll_scheduler_timer.sv
// acc_poll_timer: free-running 0..POLL_DIV-1 counter, one-cycle tick on the wrap cycle.
module acc_poll_timer #(
    parameter int unsigned POLL_DIV = 12000
) (
    input  logic clk12M,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(POLL_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk12M) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acc_poll_scheduler.sv
// acc_poll_scheduler: one config write after reset, then six byte reads per poll tick into a sample.
// Build option ACC_RETRY_EN: retry a failed transaction up to 3 times before entering ERROR.
module acc_poll_scheduler
    import acc_pkg::*;
#(
    parameter int unsigned POLL_DIV    = 12000,
    parameter logic [7:0]  INIT_REG    = ACC_INIT_REG,
    parameter logic [7:0]  INIT_DATA   = ACC_INIT_DATA,
    parameter logic [7:0]  DATA_REG0   = ACC_DATA_REG0,
    parameter int unsigned RSP_TIMEOUT = 4095
) (
    input  logic        clk12M,
    input  logic        rst_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_rw,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [7:0]  rsp_rdata,
    output logic [15:0] acc_x,
    output logic [15:0] acc_y,
    output logic [15:0] acc_z,
    output logic        sample_valid,
    output logic        overrun,
    output logic        err
);

    localparam int unsigned TW = $clog2(RSP_TIMEOUT);

    acc_state_e      state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [TW-1:0]   to_q, to_d;
    logic [5:0][7:0] bytes_q, bytes_d;
    acc_sample_t     sample_q, sample_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_rw_q, cmd_rw_d;
    logic [7:0]      cmd_reg_q, cmd_reg_d;
    logic [7:0]      cmd_wdata_q, cmd_wdata_d;
    logic            sample_valid_q, sample_valid_d;
    logic            overrun_q, overrun_d;
    logic            err_q, err_d;
    logic            tick;
    logic            hs;
    logic            fail;
`ifdef ACC_RETRY_EN
    logic [1:0]      retry_q, retry_d;
`endif

    acc_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
        .clk12M (clk12M),
        .rst_n  (rst_n),
        .tick   (tick)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        to_d           = to_q;
        bytes_d        = bytes_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        fail           = 1'b0;
        // Handshake uses the registered strobe so the reset cycle can never be accepted.
        hs             = cmd_valid_q && cmd_ready;
        overrun_d      = tick && !(state_q == IDLE || state_q == ERROR);
`ifdef ACC_RETRY_EN
        retry_d        = retry_q;
`endif

        case (state_q)
            INIT_REQ: begin
                if (hs) begin
                    state_d = INIT_WAIT;
                    to_d    = '0;
                end
            end
            INIT_WAIT, RD_WAIT: begin
                if (rsp_valid && !rsp_nack) begin
`ifdef ACC_RETRY_EN
                    retry_d = '0;
`endif
                    if (state_q == INIT_WAIT) begin
                        state_d = IDLE;
                    end else begin
                        bytes_d[idx_q] = rsp_rdata;
                        if (idx_q == 3'd5) begin
                            state_d = PUBLISH;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = RD_REQ;
                        end
                    end
                end else if (rsp_valid || to_q == TW'(RSP_TIMEOUT - 1)) begin
                    fail = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            IDLE: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (hs) begin
                    state_d = RD_WAIT;
                    to_d    = '0;
                end
            end
            PUBLISH: begin
                sample_d.x     = {bytes_q[1], bytes_q[0]};
                sample_d.y     = {bytes_q[3], bytes_q[2]};
                sample_d.z     = {bytes_q[5], bytes_q[4]};
                sample_valid_d = 1'b1;
                state_d        = IDLE;
            end
            ERROR: begin
                if (tick) begin
                    state_d = INIT_REQ;
                end
            end
            default: state_d = INIT_REQ;
        endcase

        if (fail) begin
`ifdef ACC_RETRY_EN
            if (retry_q == 2'd3) begin
                retry_d = '0;
                state_d = ERROR;
            end else begin
                retry_d = retry_q + 2'd1;
                state_d = (state_q == INIT_WAIT) ? INIT_REQ : RD_REQ;
            end
`else
            state_d = ERROR;
`endif
        end

        // Command fields are registered from the next state and held outside the request states.
        cmd_valid_d = (state_d == INIT_REQ) || (state_d == RD_REQ);
        cmd_rw_d    = cmd_rw_q;
        cmd_reg_d   = cmd_reg_q;
        cmd_wdata_d = cmd_wdata_q;
        if (state_d == INIT_REQ) begin
            cmd_rw_d    = 1'b0;
            cmd_reg_d   = INIT_REG;
            cmd_wdata_d = INIT_DATA;
        end else if (state_d == RD_REQ) begin
            cmd_rw_d    = 1'b1;
            cmd_reg_d   = DATA_REG0 + {5'd0, idx_d};
            cmd_wdata_d = '0;
        end
        err_d = (state_d == ERROR);
    end

    always_ff @(posedge clk12M) begin
        if (!rst_n) begin
            state_q        <= INIT_REQ;
            idx_q          <= '0;
            to_q           <= '0;
            bytes_q        <= '0;
            sample_q       <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_rw_q       <= 1'b0;
            cmd_reg_q      <= '0;
            cmd_wdata_q    <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            to_q           <= to_d;
            bytes_q        <= bytes_d;
            sample_q       <= sample_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_rw_q       <= cmd_rw_d;
            cmd_reg_q      <= cmd_reg_d;
            cmd_wdata_q    <= cmd_wdata_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            err_q          <= err_d;
        end
    end

`ifdef ACC_RETRY_EN
    always_ff @(posedge clk12M) begin
        if (!rst_n) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign cmd_valid    = cmd_valid_q;
    assign cmd_rw       = cmd_rw_q;
    assign cmd_reg      = cmd_reg_q;
    assign cmd_wdata    = cmd_wdata_q;
    assign acc_x        = sample_q.x;
    assign acc_y        = sample_q.y;
    assign acc_z        = sample_q.z;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
    assign err          = err_q;

endmodule

// File: tb/tb_acc_poll_scheduler.sv
// Bench for acc_poll_scheduler: randomized I2C engine stand-in checked cycle by cycle against a transaction model.
module tb_acc_poll_scheduler;

    localparam int unsigned PDIV  = 20;
    localparam int          TMO   = 4095;
`ifdef ACC_RETRY_EN
    localparam int          NACKS = 4;
`else
    localparam int          NACKS = 1;
`endif

    logic        clk12M = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [7:0]  cmd_reg, cmd_wdata;
    logic        rsp_valid, rsp_nack;
    logic [7:0]  rsp_rdata;
    logic [15:0] acc_x, acc_y, acc_z;
    logic        sample_valid, overrun, err;

    always #5 clk12M = ~clk12M;

    acc_poll_scheduler #(
        .POLL_DIV    (PDIV),
        .RSP_TIMEOUT (TMO)
    ) dut (
        .clk12M       (clk12M),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_reg      (cmd_reg),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_nack     (rsp_nack),
        .rsp_rdata    (rsp_rdata),
        .acc_x        (acc_x),
        .acc_y        (acc_y),
        .acc_z        (acc_z),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .err          (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit abort = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
            if (n_bad >= 40) abort = 1'b1;
        end
    endtask

    // Reference model: which part of the transaction sequence the scheduler should be in.
    typedef enum {ASK, LISTEN, EMIT, REST, FAULT} phase_e;
    phase_e      ph;
    int          seq;
    int          age;
    int          tries;
    logic [7:0]  bm [6];
    logic        e_cv, e_rw, e_sv, e_ov, e_err;
    logic [7:0]  e_reg, e_wd;
    logic [15:0] e_x, e_y, e_z;
    int          edge_k;

    // Engine stand-in knobs and state
    int          p_ready = 100, lat_max = 1, p_nack = 0, p_spur = 0;
    int          eng_cnt = 0;
    logic [7:0]  eng_reg = 8'h00;
    logic [7:0]  drop_reg = 8'h00;
    int          drop_left = 0, nack_left = 0, n34 = 0;
    bit          use_tab = 1'b0;
    logic [7:0]  tab [6];
    logic [7:0]  hs_regs [$];
    int          n_sv = 0, n_ov = 0;

    task automatic model_edge(input bit tk, input bit rdy, input bit rv, input bit nk, input logic [7:0] rd);
        bit failed;
        failed = 1'b0;
        e_ov = tk && !(ph == REST || ph == FAULT);
        e_sv = 1'b0;
        case (ph)
            ASK: if (e_cv && rdy) begin ph = LISTEN; age = 0; end
            LISTEN: begin
                if (rv && !nk) begin
                    tries = 0;
                    if (seq < 0) ph = REST;
                    else begin
                        bm[seq] = rd;
                        if (seq == 5) ph = EMIT;
                        else begin seq++; ph = ASK; end
                    end
                end else if (rv || age == TMO - 1) failed = 1'b1;
                else age++;
            end
            EMIT: begin
                e_x  = 16'(int'($signed(bm[1])) * 256 + int'(bm[0]));
                e_y  = 16'(int'($signed(bm[3])) * 256 + int'(bm[2]));
                e_z  = 16'(int'($signed(bm[5])) * 256 + int'(bm[4]));
                e_sv = 1'b1;
                ph   = REST;
            end
            REST:  if (tk) begin seq = 0; ph = ASK; end
            FAULT: if (tk) begin seq = -1; ph = ASK; end
        endcase
        if (failed) begin
`ifdef ACC_RETRY_EN
            if (tries < 3) begin tries++; ph = ASK; end
            else begin tries = 0; ph = FAULT; end
`else
            ph = FAULT;
`endif
        end
        e_cv = (ph == ASK);
        if (e_cv) begin
            e_rw  = (seq >= 0);
            e_reg = (seq < 0) ? 8'h2D : 8'(8'h32 + seq);
            e_wd  = (seq < 0) ? 8'h08 : 8'h00;
        end
        e_err = (ph == FAULT);
    endtask

    task automatic step();
        bit tk;
        @(negedge clk12M);
        if (abort) return;
        check("cmd_valid", 32'(cmd_valid), 32'(e_cv));
        check("cmd_rw", 32'(cmd_rw), 32'(e_rw));
        check("cmd_reg", 32'(cmd_reg), 32'(e_reg));
        check("cmd_wdata", 32'(cmd_wdata), 32'(e_wd));
        check("acc_x", 32'(acc_x), 32'(e_x));
        check("acc_y", 32'(acc_y), 32'(e_y));
        check("acc_z", 32'(acc_z), 32'(e_z));
        check("sample_valid", 32'(sample_valid), 32'(e_sv));
        check("overrun", 32'(overrun), 32'(e_ov));
        check("err", 32'(err), 32'(e_err));
        if (sample_valid) n_sv++;
        if (overrun) n_ov++;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        rsp_rdata = 8'h00;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                rsp_valid = 1'b1;
                if (nack_left > 0) begin rsp_nack = 1'b1; nack_left--; end
                else rsp_nack = ($urandom_range(99) < p_nack);
                rsp_rdata = (use_tab && eng_reg >= 8'h32 && eng_reg <= 8'h37) ? tab[eng_reg - 8'h32]
                                                                              : 8'($urandom);
            end
        end else if ($urandom_range(99) < p_spur) begin
            rsp_valid = 1'b1;
            rsp_nack  = 1'($urandom_range(1));
            rsp_rdata = 8'($urandom);
        end
        cmd_ready = ($urandom_range(99) < p_ready);
        if (cmd_valid && cmd_ready) begin
            hs_regs.push_back(cmd_reg);
            eng_reg = cmd_reg;
            if (cmd_reg == 8'h34) n34++;
            if (drop_left > 0 && cmd_reg == drop_reg) drop_left--;
            else eng_cnt = $urandom_range(lat_max, 1);
        end
        tk = ((edge_k % PDIV) == PDIV - 1);
        edge_k++;
        model_edge(tk, cmd_ready, rsp_valid, rsp_nack, rsp_rdata);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // kind: 0 sample_valid, 1 err, 2 cmd_valid, 3 second command to reg 8'h34
    task automatic wait_for(input int kind, input int max, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max && !hit && !abort; i++) begin
            step();
            case (kind)
                0: hit = sample_valid;
                1: hit = err;
                2: hit = cmd_valid;
                default: hit = (n34 >= 2);
            endcase
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk12M);
        rst_n = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
        repeat (2) @(negedge clk12M);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_rw", 32'(cmd_rw), 32'd0);
        check("rst_cmd_reg", 32'(cmd_reg), 32'd0);
        check("rst_cmd_wdata", 32'(cmd_wdata), 32'd0);
        check("rst_acc", {16'd0, acc_x | acc_y | acc_z}, 32'd0);
        check("rst_flags", 32'({sample_valid, overrun, err}), 32'd0);
        ph = ASK; seq = -1; age = 0; tries = 0;
        e_cv = 0; e_rw = 0; e_reg = 0; e_wd = 0; e_x = 0; e_y = 0; e_z = 0;
        e_sv = 0; e_ov = 0; e_err = 0;
        eng_cnt = 0;
        rst_n = 1'b1;
        edge_k = 0;
        model_edge(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        edge_k = 1;
    endtask

    initial begin
        logic [7:0] reg0;
        int         n_sv0, n_ov0;
        rst_n = 1'b0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
        tab[0] = 8'h10; tab[1] = 8'h00; tab[2] = 8'hF0;
        tab[3] = 8'hFF; tab[4] = 8'h00; tab[5] = 8'h01;

        do_reset();
        step();
        check("init_valid", 32'(cmd_valid), 32'd1);
        check("init_rw", 32'(cmd_rw), 32'd0);
        check("init_reg", 32'(cmd_reg), 32'h2D);
        check("init_wdata", 32'(cmd_wdata), 32'h08);
        run(5);
        check("init_idle_valid", 32'(cmd_valid), 32'd0);
        check("init_err", 32'(err), 32'd0);

        use_tab = 1'b1;
        hs_regs.delete();
        n_sv0 = n_sv;
        wait_for(0, 100, "poll_sample");
        check("poll_x", 32'(acc_x), 32'h0010);
        check("poll_y", 32'(acc_y), 32'hFFF0);
        check("poll_z", 32'(acc_z), 32'h0100);
        check("poll_nreads", 32'(hs_regs.size()), 32'd6);
        for (int i = 0; i < 6 && i < hs_regs.size(); i++)
            check("poll_reg", 32'(hs_regs[i]), 32'(8'h32 + i));
        run(2);
        check("poll_pulses", 32'(n_sv - n_sv0), 32'd1);

        p_ready = 0;
        wait_for(2, 3 * PDIV, "stall_start");
        reg0 = cmd_reg;
        run(50);
        check("stall_valid", 32'(cmd_valid), 32'd1);
        check("stall_reg", 32'(cmd_reg), 32'(reg0));
        check("stall_err", 32'(err), 32'd0);
        p_ready = 100;
        wait_for(0, 200, "stall_done");

        drop_reg = 8'h34; drop_left = 1; n34 = 0;
`ifdef ACC_RETRY_EN
        wait_for(3, 6000, "tmo_retry");
        check("tmo_retry_err", 32'(err), 32'd0);
`else
        wait_for(1, 6000, "tmo_err");
        check("tmo_acc_x", 32'(acc_x), 32'h0010);
        check("tmo_acc_y", 32'(acc_y), 32'hFFF0);
        check("tmo_acc_z", 32'(acc_z), 32'h0100);
        wait_for(2, 3 * PDIV, "tmo_reinit");
        check("tmo_reinit_reg", 32'(cmd_reg), 32'h2D);
        check("tmo_reinit_rw", 32'(cmd_rw), 32'd0);
        check("tmo_reinit_err", 32'(err), 32'd0);
`endif

        wait_for(0, 300, "pre_nack");
        nack_left = NACKS;
        wait_for(1, 500, "nack_err");
        wait_for(2, 3 * PDIV, "nack_reinit");
        check("nack_reinit_reg", 32'(cmd_reg), 32'h2D);
        check("nack_reinit_wdata", 32'(cmd_wdata), 32'h08);

        use_tab = 1'b0; p_ready = 60; lat_max = 8;
        n_ov0 = n_ov;
        run(400);
        check("overrun_seen", 32'(n_ov > n_ov0), 32'd1);

        p_ready = 70; lat_max = 6; p_nack = 4; p_spur = 3;
        run(3000);
        do_reset();
        run(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
